// File: rtl/fmul_seq_if.sv
// fmul_seq_if: operand request / result handshake bundle for fmul_seq.
// master drives operands and result acceptance, slave is the multiplier.
interface fmul_seq_if #(parameter int W = 8) ();
   logic         i_valid;
   logic         o_ready;
   logic [2:0]   i_mode;
   logic [W-1:0] i_rd;
   logic [W-1:0] i_rr;
   logic         o_valid;
   logic         i_ready;
   logic [W-1:0] o_r1;
   logic [W-1:0] o_r0;
   logic         o_c;
   logic         o_z;
   logic         o_ovf;

   modport master (
      output i_valid, i_mode, i_rd, i_rr, i_ready,
      input  o_ready, o_valid, o_r1, o_r0, o_c, o_z, o_ovf
   );

   modport slave (
      input  i_valid, i_mode, i_rd, i_rr, i_ready,
      output o_ready, o_valid, o_r1, o_r0, o_c, o_z, o_ovf
   );
endinterface

// File: rtl/fmul_seq.sv
// fmul_seq: W-bit shift-add MUL/MULS/MULSU/FMUL/FMULS/FMULSU, one step per cycle.
// Define FMUL_SAT_EN to saturate the fractional (-1.0)x(-1.0) case.
module fmul_seq #(
   parameter int W = 8
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   fmul_seq_if.slave  bus
);
   localparam int CW = $clog2(W) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

   state_t         state;
   logic           frac;
   logic           sign;
   logic [W-1:0]   mcand;
   logic [W-1:0]   hi;
   logic [W-1:0]   lo;
   logic [CW-1:0]  cnt;
   logic           ready;
   logic           valid;
   logic [W-1:0]   r1;
   logic [W-1:0]   r0;
   logic           c;
   logic           z;
   logic           ovf;
`ifdef FMUL_SAT_EN
   logic           both_sgn;
`endif

   logic           rd_neg;
   logic           rr_neg;
   logic [W-1:0]   rd_mag;
   logic [W-1:0]   rr_mag;
   logic [W:0]     sum;
   logic [2*W-1:0] raw;
   logic [2*W-1:0] res;
   logic           ovf_n;

   // -2^(W-1) has magnitude 2^(W-1), which still fits W unsigned bits
   always_comb begin
      rd_neg = bus.i_mode[0] & bus.i_rd[W-1];
      rr_neg = bus.i_mode[1] & bus.i_rr[W-1];
      rd_mag = rd_neg ? (~bus.i_rd + 1'b1) : bus.i_rd;
      rr_mag = rr_neg ? (~bus.i_rr + 1'b1) : bus.i_rr;
   end

   always_comb begin
      sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
   end

   always_comb begin
      raw   = sign ? (~{hi, lo} + 1'b1) : {hi, lo};
      res   = frac ? {raw[2*W-2:0], 1'b0} : raw;
      ovf_n = 1'b0;
`ifdef FMUL_SAT_EN
      if (frac && both_sgn && (raw[2*W-1] != raw[2*W-2])) begin
         res   = {1'b0, {(2*W-1){1'b1}}};
         ovf_n = 1'b1;
      end
`endif
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= IDLE;
         frac  <= 1'b0;
         sign  <= 1'b0;
         mcand <= '0;
         hi    <= '0;
         lo    <= '0;
         cnt   <= '0;
         ready <= 1'b1;
         valid <= 1'b0;
         r1    <= '0;
         r0    <= '0;
         c     <= 1'b0;
         z     <= 1'b0;
         ovf   <= 1'b0;
`ifdef FMUL_SAT_EN
         both_sgn <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.i_valid) begin
                  frac  <= bus.i_mode[2];
                  sign  <= rd_neg ^ rr_neg;
                  mcand <= rd_mag;
                  hi    <= '0;
                  lo    <= rr_mag;
                  cnt   <= '0;
                  ready <= 1'b0;
                  state <= CALC;
`ifdef FMUL_SAT_EN
                  both_sgn <= &bus.i_mode[1:0];
`endif
               end
            end
            CALC: begin
               hi  <= sum[W:1];
               lo  <= {sum[0], lo[W-1:1]};
               cnt <= cnt + 1'b1;
               if (cnt == CW'(W - 1)) state <= FIN;
            end
            FIN: begin
               r1    <= res[2*W-1:W];
               r0    <= res[W-1:0];
               c     <= raw[2*W-1];
               z     <= (res == '0);
               ovf   <= ovf_n;
               valid <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               if (bus.i_ready) begin
                  valid <= 1'b0;
                  ready <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_ready = ready;
   assign bus.o_valid = valid;
   assign bus.o_r1    = r1;
   assign bus.o_r0    = r0;
   assign bus.o_c     = c;
   assign bus.o_z     = z;
   assign bus.o_ovf   = ovf;
endmodule

// File: tb/tb_fmul_seq.sv
// tb_fmul_seq: directed vectors for fmul_seq at W=8 and W=16.
// Expected products are hand-computed constants.
module tb_fmul_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

`ifdef FMUL_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   fmul_seq_if #(.W(8))  b8 ();
   fmul_seq_if #(.W(16)) b16 ();

   fmul_seq #(.W(8))  u8  (.i_clk(clk), .i_rst_n(rst_n), .bus(b8));
   fmul_seq #(.W(16)) u16 (.i_clk(clk), .i_rst_n(rst_n), .bus(b16));

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic issue8(input logic [2:0] m, input logic [7:0] a,
                         input logic [7:0] b);
      @(negedge clk);
      b8.i_valid = 1'b1;
      b8.i_mode  = m;
      b8.i_rd    = a;
      b8.i_rr    = b;
      @(posedge clk);
      #1 b8.i_valid = 1'b0;
   endtask

   task automatic wait8(output int lat, output bit rdy_hi);
      lat    = 0;
      rdy_hi = 1'b0;
      while (!b8.o_valid && lat < 40) begin
         @(posedge clk);
         #1 lat++;
         if (b8.o_ready) rdy_hi = 1'b1;
      end
   endtask

   task automatic take8(input string tag);
      @(negedge clk);
      b8.i_ready = 1'b1;
      @(posedge clk);
      #1 b8.i_ready = 1'b0;
      chk({tag, "_rdy"}, 64'(b8.o_ready), 64'd1);
      chk({tag, "_vld"}, 64'(b8.o_valid), 64'd0);
   endtask

   task automatic op8(input string tag, input logic [2:0] m,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp, input bit ec,
                      input bit ez, input bit eo);
      int lat;
      bit rh;
      issue8(m, a, b);
      wait8(lat, rh);
      chk({tag, "_lat"}, 64'(lat), 64'd9);
      chk({tag, "_busy"}, 64'(rh), 64'd0);
      chk({tag, "_res"}, 64'({b8.o_r1, b8.o_r0}), 64'(exp));
      chk({tag, "_c"}, 64'(b8.o_c), 64'(ec));
      chk({tag, "_z"}, 64'(b8.o_z), 64'(ez));
      chk({tag, "_ovf"}, 64'(b8.o_ovf), 64'(eo));
      take8(tag);
   endtask

   task automatic op16(input string tag, input logic [2:0] m,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input bit ec,
                       input bit ez);
      int lat = 0;
      @(negedge clk);
      b16.i_valid = 1'b1;
      b16.i_mode  = m;
      b16.i_rd    = a;
      b16.i_rr    = b;
      @(posedge clk);
      #1 b16.i_valid = 1'b0;
      while (!b16.o_valid && lat < 60) begin
         @(posedge clk);
         #1 lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'd17);
      chk({tag, "_res"}, 64'({b16.o_r1, b16.o_r0}), 64'(exp));
      chk({tag, "_c"}, 64'(b16.o_c), 64'(ec));
      chk({tag, "_z"}, 64'(b16.o_z), 64'(ez));
      @(negedge clk);
      b16.i_ready = 1'b1;
      @(posedge clk);
      #1 b16.i_ready = 1'b0;
      chk({tag, "_rdy"}, 64'(b16.o_ready), 64'd1);
   endtask

   initial begin
      int lat;
      bit rh;
      bit seen;
      b8.i_valid  = 1'b0;
      b8.i_ready  = 1'b0;
      b8.i_mode   = '0;
      b8.i_rd     = '0;
      b8.i_rr     = '0;
      b16.i_valid = 1'b0;
      b16.i_ready = 1'b0;
      b16.i_mode  = '0;
      b16.i_rd    = '0;
      b16.i_rr    = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rdy", 64'(b8.o_ready), 64'd1);
      chk("rst_vld", 64'(b8.o_valid), 64'd0);
      chk("rst_res", 64'({b8.o_r1, b8.o_r0}), 64'd0);
      chk("rst_flags", 64'({b8.o_c, b8.o_z, b8.o_ovf}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      op8("mul_ff", 3'b000, 8'hFF, 8'hFF, 16'hFE01, 1'b1, 1'b0, 1'b0);
      op8("muls", 3'b011, 8'h80, 8'h02, 16'hFF00, 1'b1, 1'b0, 1'b0);
      op8("mulsu", 3'b001, 8'hFF, 8'hFF, 16'hFF01, 1'b1, 1'b0, 1'b0);
      op8("fmuls", 3'b111, 8'h40, 8'hC0, 16'hE000, 1'b1, 1'b0, 1'b0);
      op8("fzero", 3'b111, 8'h00, 8'h5A, 16'h0000, 1'b0, 1'b1, 1'b0);
      op8("fm1m1", 3'b111, 8'h80, 8'h80, SAT ? 16'h7FFF : 16'h8000,
          1'b0, 1'b0, SAT);
      op8("mulsu_r", 3'b010, 8'h03, 8'hFE, 16'hFFFA, 1'b1, 1'b0, 1'b0);

      // stray i_valid/i_ready during CALC, then backpressure in DONE
      issue8(3'b000, 8'h0C, 8'h0D);
      @(negedge clk);
      b8.i_valid = 1'b1;
      b8.i_ready = 1'b1;
      b8.i_rd    = 8'h11;
      b8.i_rr    = 8'h22;
      repeat (3) @(posedge clk);
      #1;
      b8.i_valid = 1'b0;
      b8.i_ready = 1'b0;
      wait8(lat, rh);
      chk("bp_vld", 64'(b8.o_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_hold_vld", 64'(b8.o_valid), 64'd1);
         chk("bp_hold_res", 64'({b8.o_r1, b8.o_r0}), 64'h009C);
      end
      take8("bp");
      seen = 1'b0;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk);
         #1 if (b8.o_valid) seen = 1'b1;
      end
      chk("bp_no_second", 64'(seen), 64'd0);
      chk("bp_kept", 64'({b8.o_r1, b8.o_r0}), 64'h009C);

      // reset on CALC step 3 discards the in-flight product
      issue8(3'b011, 8'h80, 8'h02);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rdy", 64'(b8.o_ready), 64'd1);
      chk("mid_vld", 64'(b8.o_valid), 64'd0);
      chk("mid_res", 64'({b8.o_r1, b8.o_r0}), 64'd0);
      chk("mid_flags", 64'({b8.o_c, b8.o_z, b8.o_ovf}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk);
         #1 if (b8.o_valid) seen = 1'b1;
      end
      chk("mid_no_vld", 64'(seen), 64'd0);
      op8("post_rst", 3'b001, 8'hFF, 8'hFF, 16'hFF01, 1'b1, 1'b0, 1'b0);

      op16("w16_muls", 3'b011, 16'h8000, 16'h8000, 32'h4000_0000,
           1'b0, 1'b0);
      op16("w16_mul", 3'b000, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001,
           1'b1, 1'b0);
      op16("w16_fmuls", 3'b111, 16'h4000, 16'hC000, 32'hE000_0000,
           1'b1, 1'b0);
      op16("w16_fzero", 3'b111, 16'h0000, 16'h5A5A, 32'h0000_0000,
           1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
